fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the 16-bit core. It owns the program counter, drives the byte address of the instruction memory (IM) every cycle, and registers the returned word into a one-entry IF/ID output slot with a valid/ready handshake. It also handles branch/jump redirects from the execute stage and stops fetching when it fetches the halt word. It sits between IM and the decode stage.

---
 rtl/fetch_ctrl.sv | 110 +++++++++++
 tb/tb_fetch_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer for the 16-bit core.
// Owns the PC, addresses instruction memory every cycle and registers the
// returned word into a one-entry IF/ID slot with a valid/ready handshake.
// Redirects from execute take priority over sequential fetch. Fetching the
// halt word parks the sequencer in HALT until a redirect or reset.
module fetch_ctrl #(
    parameter int                 ADDR_W    = 8,
    parameter int                 INSTR_W   = 16,
    parameter int                 PC_STEP   = 2,
    parameter logic [ADDR_W-1:0]  RESET_PC  = 8'h00,
    parameter logic [INSTR_W-1:0] HALT_WORD = 16'h0000
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    input  logic               id_ready,
    output logic               halted,
    output logic [15:0]        fetch_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [1:0]         state_reg,    state_next;
    logic [ADDR_W-1:0]  pc_reg,       pc_next;
    logic               valid_reg,    valid_next;
    logic [INSTR_W-1:0] instr_reg,    instr_next;
    logic [ADDR_W-1:0]  ipc_reg,      ipc_next;
    logic [15:0]        count_reg,    count_next;

    logic accept;
    logic slot_free;
    logic fetch;

    assign accept    = valid_reg & id_ready;
    assign slot_free = ~valid_reg | id_ready;
    assign fetch     = (state_reg == ST_RUN) & slot_free & ~redirect_valid;

    assign imem_addr   = pc_reg;
    assign if_valid    = valid_reg;
    assign if_instr    = instr_reg;
    assign if_pc       = ipc_reg;
    assign halted      = (state_reg == ST_HALT);
    assign fetch_count = count_reg;

    // Next-state decision: IDLE warm-up, then redirect > fetch > plain accept.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        valid_next = valid_reg;
        instr_next = instr_reg;
        ipc_next   = ipc_reg;
        count_next = count_reg;

        if (state_reg == ST_IDLE) begin
            // One idle cycle lets IM settle; redirects are ignored here.
            state_next = ST_RUN;
            if (accept) begin
                valid_next = 1'b0;
            end
        end else if (redirect_valid) begin
            // Targets are forced even; the slot is flushed even if accepted.
            pc_next    = {redirect_pc[ADDR_W-1:1], 1'b0};
            valid_next = 1'b0;
            state_next = ST_RUN;
        end else if (fetch) begin
            instr_next = imem_data;
            ipc_next   = pc_reg;
            valid_next = 1'b1;
            if (count_reg != 16'hFFFF) begin
                count_next = count_reg + 16'd1;
            end
            if (imem_data == HALT_WORD) begin
                // The halt word is still delivered, but the PC parks on it.
                state_next = ST_HALT;
            end else begin
                pc_next = pc_reg + ADDR_W'(PC_STEP);
            end
        end else if (accept) begin
            valid_next = 1'b0;
        end
    end

    // State and slot registers with synchronous reset overriding everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            pc_reg    <= RESET_PC;
            valid_reg <= 1'b0;
            instr_reg <= '0;
            ipc_reg   <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            valid_reg <= valid_next;
            instr_reg <= instr_next;
            ipc_reg   <= ipc_next;
            count_reg <= count_next;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a transaction-level reference model
// predicts the visible slot/PC state after every edge and the sequence of
// instructions decode should accept; two monitors compare independently.
module tb_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [7:0]  if_pc;
    logic        id_ready;
    logic        halted;
    logic [15:0] fetch_count;

    fetch_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .id_ready       (id_ready),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory, word-indexed by byte address / 2.
    logic [15:0] mem [0:127];
    assign imem_data = mem[imem_addr[7:1]];

    typedef struct {
        logic        v;
        logic [7:0]  ipc;
        logic [15:0] ins;
        logic        h;
        logic [15:0] cnt;
        logic [7:0]  addr;
    } exp_t;

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] ins;
    } xact_t;

    exp_t  exp_q[$];
    xact_t acc_q[$];

    int total = 0;
    int bad   = 0;

    // Reference model: mode names only, slot held as a queue of transactions.
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;
    int          m_mode;
    logic [7:0]  m_pc;
    xact_t       m_slot[$];
    logic [7:0]  m_last_pc;
    logic [15:0] m_last_ins;
    int          m_count;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_mode     = M_IDLE;
        m_pc       = 8'h00;
        m_slot.delete();
        m_last_pc  = 8'h00;
        m_last_ins = 16'h0000;
        m_count    = 0;
    endtask

    // Drive one cycle of inputs, advance the model, queue expectations,
    // then advance to 2ns after the edge those inputs act on.
    task automatic step(input logic rst, input logic rv, input logic [7:0] rpc, input logic rdy);
        logic  full;
        exp_t  e;
        xact_t x;
        reset          = rst;
        redirect_valid = rv;
        redirect_pc    = rpc;
        id_ready       = rdy;
        if (rst) begin
            model_reset();
        end else begin
            full = (m_slot.size() != 0);
            if (full && rdy) acc_q.push_back(m_slot[0]);
            if (m_mode == M_IDLE) begin
                m_mode = M_RUN;
                if (full && rdy) m_slot.delete();
            end else if (rv) begin
                m_pc   = rpc & 8'hFE;
                m_slot.delete();
                m_mode = M_RUN;
            end else if (m_mode == M_RUN && (!full || rdy)) begin
                x.pc  = m_pc;
                x.ins = mem[m_pc >> 1];
                m_slot.delete();
                m_slot.push_back(x);
                m_last_pc  = x.pc;
                m_last_ins = x.ins;
                if (m_count < 65535) m_count++;
                if (x.ins == 16'h0000) m_mode = M_HALT;
                else m_pc = 8'((int'(m_pc) + 2) % 256);
            end else if (full && rdy) begin
                m_slot.delete();
            end
        end
        e.v    = (m_slot.size() != 0);
        e.ipc  = m_last_pc;
        e.ins  = m_last_ins;
        e.h    = (m_mode == M_HALT);
        e.cnt  = 16'(m_count);
        e.addr = m_pc;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // State monitor: compare visible registers just after every edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("if_valid",    32'(if_valid),    32'(e.v));
            chk("if_pc",       32'(if_pc),       32'(e.ipc));
            chk("if_instr",    32'(if_instr),    32'(e.ins));
            chk("halted",      32'(halted),      32'(e.h));
            chk("fetch_count", 32'(fetch_count), 32'(e.cnt));
            chk("imem_addr",   32'(imem_addr),   32'(e.addr));
        end
    end

    // Accept monitor: every handshake must match the next expected delivery.
    always @(negedge clk) begin
        if (reset === 1'b0 && if_valid === 1'b1 && id_ready === 1'b1) begin
            if (acc_q.size() == 0) begin
                chk("accept_unexpected", 32'(if_pc), 32'hFFFF_FFFF);
            end else begin
                xact_t x;
                x = acc_q.pop_front();
                chk("accept_pc",    32'(if_pc),    32'(x.pc));
                chk("accept_instr", 32'(if_instr), 32'(x.ins));
                $display("accept pc=%02h instr=%04h", if_pc, if_instr);
            end
        end
    end

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 16'h8000 | 16'((i * 16'h0137) & 16'h7FFF) | 16'h0001;
        mem[0]  = 16'hF120;
        mem[1]  = 16'hF121;
        mem[2]  = 16'h93FF;
        mem[3]  = 16'h834C;
        mem[21] = 16'hF880;
        mem[27] = 16'hEFFF;
        mem[28] = 16'h0000;

        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 8'h00; id_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #2;

        // Reset, then straight-line run into the halt word at 0x38.
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        chk("rst_valid", 32'(if_valid), 0);
        chk("rst_addr",  32'(imem_addr), 0);
        step(0, 0, 0, 1);
        chk("idle_no_valid", 32'(if_valid), 0);
        step(0, 0, 0, 1);
        chk("first_pc",    32'(if_pc), 32'h00);
        chk("first_instr", 32'(if_instr), 32'hF120);
        for (int i = 0; i < 31; i++) step(0, 0, 0, 1);
        chk("sl_halted", 32'(halted), 1);
        chk("sl_count",  32'(fetch_count), 29);
        chk("sl_pc",     32'(imem_addr), 32'h38);

        // Redirect out of HALT to 0x00.
        step(0, 1, 8'h00, 1);
        chk("rh_halted", 32'(halted), 0);
        step(0, 0, 0, 1);
        chk("rh_pc",    32'(if_pc), 32'h00);
        chk("rh_instr", 32'(if_instr), 32'hF120);

        // Back-pressure while the slot holds 0x04.
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0);
            chk("bp_pc",    32'(if_pc), 32'h04);
            chk("bp_instr", 32'(if_instr), 32'h93FF);
            chk("bp_addr",  32'(imem_addr), 32'h06);
        end
        step(0, 0, 0, 1);
        chk("bp_next_pc",    32'(if_pc), 32'h06);
        chk("bp_next_instr", 32'(if_instr), 32'h834C);

        // Redirect to odd target 0x2B while the slot holds 0x0A.
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("rd_slot", 32'(if_pc), 32'h0A);
        step(0, 1, 8'h2B, 1);
        chk("rd_flush", 32'(if_valid), 0);
        step(0, 0, 0, 1);
        chk("rd_pc",    32'(if_pc), 32'h2A);
        chk("rd_instr", 32'(if_instr), 32'hF880);

        // PC wrap from 0xFE to 0x00.
        step(0, 1, 8'hFE, 1);
        step(0, 0, 0, 1);
        chk("wrap_fe", 32'(if_pc), 32'hFE);
        step(0, 0, 0, 1);
        chk("wrap_00", 32'(if_pc), 32'h00);

        // Reset in the middle of a stall.
        step(0, 0, 0, 0);
        chk("ms_full", 32'(if_valid), 1);
        step(1, 0, 0, 0);
        chk("ms_valid", 32'(if_valid), 0);
        chk("ms_count", 32'(fetch_count), 0);
        chk("ms_addr",  32'(imem_addr), 0);
        step(0, 0, 0, 1);
        chk("ms_idle", 32'(if_valid), 0);
        step(0, 0, 0, 1);
        chk("ms_first", 32'(if_valid), 1);

        // Randomized traffic: back-pressure, redirects (incl. odd targets), rare resets.
        for (int i = 0; i < 600; i++) begin
            logic       r_rst, r_rv, r_rdy;
            logic [7:0] r_pc;
            r_rst = ($urandom_range(0, 99) == 0);
            r_rv  = ($urandom_range(0, 99) < 8);
            r_rdy = ($urandom_range(0, 99) < 75);
            r_pc  = ($urandom_range(0, 3) == 0) ? 8'(($urandom_range(0, 31)) + 8'h30) : 8'($urandom);
            step(r_rst, r_rv, r_pc, r_rdy);
        end

        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("acc_q_drained", 32'(acc_q.size()), 0);
        chk("exp_q_drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
